// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : bus_arbiter_pkg
// Purpose  : Shared constants and the arbitration pick function for the
//            two-master IO bus arbiter.
// Contents : IO bus width defaults, FSM state encodings, arb_pick()
// Revision : 1.0 - initial release
//==============================================================================
package bus_arbiter_pkg;

   // Default IO bus geometry.
   localparam int c_IO_BUS_WIDTH_ADDR = 32;
   localparam int c_IO_BUS_WIDTH_DATA = 32;
   localparam int c_IO_BUS_WIDTH_CTRL = 3;

   // Arbiter FSM state encoding.
   localparam logic [1:0] c_ARB_IDLE = 2'd0;
   localparam logic [1:0] c_ARB_GNT0 = 2'd1;
   localparam logic [1:0] c_ARB_GNT1 = 2'd2;

   // Round-robin pick: a tie goes to the preferred master (i_rr=1 -> M1).
   function automatic logic [1:0] arb_pick(input logic i_req0,
                                           input logic i_req1,
                                           input logic i_rr);
      logic [1:0] w_sel;
      if (i_req0 && i_req1) w_sel = i_rr ? c_ARB_GNT1 : c_ARB_GNT0;
      else if (i_req0)      w_sel = c_ARB_GNT0;
      else if (i_req1)      w_sel = c_ARB_GNT1;
      else                  w_sel = c_ARB_IDLE;
      return w_sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : bus_arbiter_if
// Purpose  : Bundles both master request/response channels and the single
//            slave-side bus seen by the arbiter.
// Modports : slave  - arbiter side (takes master requests, drives slave bus)
//            master - environment side (masters + slave device)
// Revision : 1.0 - initial release
//==============================================================================
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = c_IO_BUS_WIDTH_ADDR,
   parameter int DATA_W = c_IO_BUS_WIDTH_DATA,
   parameter int CTRL_W = c_IO_BUS_WIDTH_CTRL
) ();
   // Master 0
   logic              m0_req;
   logic              m0_lock;
   logic [ADDR_W-1:0] m0_addr;
   logic [CTRL_W-1:0] m0_ctrl;
   logic              m0_we;
   logic [DATA_W-1:0] m0_wd;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rd;
   // Master 1
   logic              m1_req;
   logic              m1_lock;
   logic [ADDR_W-1:0] m1_addr;
   logic [CTRL_W-1:0] m1_ctrl;
   logic              m1_we;
   logic [DATA_W-1:0] m1_wd;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rd;
   // Slave bus
   logic [ADDR_W-1:0] s_addr;
   logic [CTRL_W-1:0] s_ctrl;
   logic              s_we;
   logic [DATA_W-1:0] s_wd;
   logic [DATA_W-1:0] s_rd;

   modport slave (
      input  m0_req, m0_lock, m0_addr, m0_ctrl, m0_we, m0_wd,
      input  m1_req, m1_lock, m1_addr, m1_ctrl, m1_we, m1_wd,
      input  s_rd,
      output m0_ack, m0_rd, m1_ack, m1_rd,
      output s_addr, s_ctrl, s_we, s_wd
   );

   modport master (
      output m0_req, m0_lock, m0_addr, m0_ctrl, m0_we, m0_wd,
      output m1_req, m1_lock, m1_addr, m1_ctrl, m1_we, m1_wd,
      output s_rd,
      input  m0_ack, m0_rd, m1_ack, m1_rd,
      input  s_addr, s_ctrl, s_we, s_wd
   );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter_sat_counter.sv
`default_nettype none
//==============================================================================
// Module   : arb_sat_counter
// Purpose  : Saturating event counter with synchronous clear (clear wins
//            over increment).
// Ports    : clk, rst (async, active-high), i_inc, i_clr, o_cnt[STAT_W]
// Revision : 1.0 - initial release
//==============================================================================
module arb_sat_counter #(
   parameter int STAT_W = 16
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              i_inc,
   input  wire              i_clr,
   output logic [STAT_W-1:0] o_cnt
);
   logic [STAT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {STAT_W{1'b1}})) begin
         r_cnt <= r_cnt + STAT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : bus_arbiter
// Purpose  : Two-master registered round-robin arbiter for the shared IO bus,
//            with locked bursts bounded by a hold limit.
// Ports    : clk, rst (async, active-high)
//            bus        - bus_arbiter_if.slave (both masters + slave bus)
//            i_stat_clr - clear grant statistics      (ARB_STATS_EN only)
//            o_m0_gcnt  - M0 acked-beat count         (ARB_STATS_EN only)
//            o_m1_gcnt  - M1 acked-beat count         (ARB_STATS_EN only)
// Macros   : ARB_STATS_EN - adds saturating per-master beat counters
// Revision : 1.0 - initial release
//==============================================================================
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W   = c_IO_BUS_WIDTH_ADDR,
   parameter int DATA_W   = c_IO_BUS_WIDTH_DATA,
   parameter int CTRL_W   = c_IO_BUS_WIDTH_CTRL,
   parameter int MAX_HOLD = 16,
   parameter int STAT_W   = 16
) (
   input  wire                clk,
   input  wire                rst,
   bus_arbiter_if.slave       bus
`ifdef ARB_STATS_EN
   ,
   input  wire                i_stat_clr,
   output logic [STAT_W-1:0]  o_m0_gcnt,
   output logic [STAT_W-1:0]  o_m1_gcnt
`endif
);
   localparam int                c_HOLD_W   = $clog2(MAX_HOLD + 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);

   logic [1:0]          r_state;
   logic                r_rr_ptr;     // 1 -> M1 preferred on a tie
   logic [c_HOLD_W-1:0] r_hold_cnt;

   logic [1:0]          w_state_nxt;
   logic                w_rr_nxt;
   logic [c_HOLD_W-1:0] w_hold_nxt;
   logic [1:0]          w_pick;
   logic                w_release;
   logic                w_force;
   logic                w_load;

   logic                w_ack0;
   logic                w_ack1;
   logic [ADDR_W-1:0]   w_s_addr;
   logic [CTRL_W-1:0]   w_s_ctrl;
   logic                w_s_we;
   logic [DATA_W-1:0]   w_s_wd;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_ARB_IDLE;
         r_rr_ptr   <= 1'b0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_pick      = arb_pick(bus.m0_req, bus.m1_req, r_rr_ptr);
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_hold_nxt  = r_hold_cnt;
      w_release   = 1'b0;
      w_force     = 1'b0;

      case (r_state)
         c_ARB_IDLE: begin
            w_state_nxt = w_pick;
         end
         c_ARB_GNT0: begin
            // A still-locked burst is cut only when the other side is waiting.
            w_force   = bus.m0_req && bus.m0_lock && bus.m1_req &&
                        (r_hold_cnt == c_HOLD_MAX);
            w_release = !bus.m0_req || !bus.m0_lock || w_force;
            if (w_force)        w_state_nxt = c_ARB_GNT1;
            else if (w_release) w_state_nxt = w_pick;
         end
         c_ARB_GNT1: begin
            w_force   = bus.m1_req && bus.m1_lock && bus.m0_req &&
                        (r_hold_cnt == c_HOLD_MAX);
            w_release = !bus.m1_req || !bus.m1_lock || w_force;
            if (w_force)        w_state_nxt = c_ARB_GNT0;
            else if (w_release) w_state_nxt = w_pick;
         end
         default: begin
            w_state_nxt = c_ARB_IDLE;
         end
      endcase

      // Fresh grant (from IDLE or after a release, including a re-grant of
      // the same master): restart the hold window and prefer the other side.
      w_load = ((r_state == c_ARB_IDLE) || w_release) &&
               (w_state_nxt != c_ARB_IDLE);

      if (w_load) begin
         w_hold_nxt = c_HOLD_W'(1);
         w_rr_nxt   = (w_state_nxt == c_ARB_GNT0);
      end else if (w_state_nxt == c_ARB_IDLE) begin
         w_hold_nxt = '0;
      end else if (r_hold_cnt != c_HOLD_MAX) begin
         w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
      end
   end

   //---------------------------------------------------------------------------
   // Output logic: ack follows the live request, so a dropped request
   // produces no beat and the slave bus is idle-driven to zero.
   //---------------------------------------------------------------------------
   always_comb begin
      w_ack0   = (r_state == c_ARB_GNT0) && bus.m0_req;
      w_ack1   = (r_state == c_ARB_GNT1) && bus.m1_req;
      w_s_addr = '0;
      w_s_ctrl = '0;
      w_s_we   = 1'b0;
      w_s_wd   = '0;
      if (w_ack0) begin
         w_s_addr = bus.m0_addr;
         w_s_ctrl = bus.m0_ctrl;
         w_s_we   = bus.m0_we;
         w_s_wd   = bus.m0_wd;
      end else if (w_ack1) begin
         w_s_addr = bus.m1_addr;
         w_s_ctrl = bus.m1_ctrl;
         w_s_we   = bus.m1_we;
         w_s_wd   = bus.m1_wd;
      end
   end

   assign bus.m0_ack = w_ack0;
   assign bus.m1_ack = w_ack1;
   assign bus.s_addr = w_s_addr;
   assign bus.s_ctrl = w_s_ctrl;
   assign bus.s_we   = w_s_we;
   assign bus.s_wd   = w_s_wd;
   assign bus.m0_rd  = bus.s_rd;
   assign bus.m1_rd  = bus.s_rd;

`ifdef ARB_STATS_EN
   arb_sat_counter #(.STAT_W(STAT_W)) u_m0_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_ack0),
      .i_clr (i_stat_clr),
      .o_cnt (o_m0_gcnt)
   );

   arb_sat_counter #(.STAT_W(STAT_W)) u_m1_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_ack1),
      .i_clr (i_stat_clr),
      .o_cnt (o_m1_gcnt)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter (MAX_HOLD=4,
//            STAT_W=4). Statistic checks are built when ARB_STATS_EN is set.
// Revision : 1.0 - initial release
//==============================================================================
module tb_bus_arbiter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CTRL_W(3)) bus ();

`ifdef ARB_STATS_EN
   logic       stat_clr;
   logic [3:0] m0_gcnt;
   logic [3:0] m1_gcnt;
`endif

   bus_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .CTRL_W   (3),
      .MAX_HOLD (4),
      .STAT_W   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave)
`ifdef ARB_STATS_EN
      ,
      .i_stat_clr (stat_clr),
      .o_m0_gcnt  (m0_gcnt),
      .o_m1_gcnt  (m1_gcnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.m0_req = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = '0;
      bus.m0_ctrl = '0;  bus.m0_we = 1'b0;   bus.m0_wd = '0;
      bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = '0;
      bus.m1_ctrl = '0;  bus.m1_we = 1'b0;   bus.m1_wd = '0;
      bus.s_rd = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      logic exp0;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
`ifdef ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      idle_inputs();
      #12;
      // Reset state
      chk("rst_m0_ack", bus.m0_ack, 0);
      chk("rst_m1_ack", bus.m1_ack, 0);
      chk("rst_s_addr", bus.s_addr, 0);
      chk("rst_s_we",   bus.s_we,   0);
      rst = 1'b0;

      // 1: single unlocked master streams with no bubble
      bus.m0_req  = 1'b1;
      bus.m0_addr = 32'h10;
      bus.m0_ctrl = 3'd2;
      #1;
      chk("t1_idle_no_ack", bus.m0_ack, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_m0_ack",  bus.m0_ack, 1);
         chk("t1_m1_ack",  bus.m1_ack, 0);
         chk("t1_s_addr",  bus.s_addr, 32'h10);
      end
      chk("t1_s_ctrl", bus.s_ctrl, 3'd2);
      bus.s_rd = 32'hDEADBEEF;
      #1;
      chk("t1_m0_rd", bus.m0_rd, 32'hDEADBEEF);
      chk("t1_m1_rd", bus.m1_rd, 32'hDEADBEEF);
      bus.m0_req = 1'b0;
      #1;
      chk("t1_drop_ack",    bus.m0_ack, 0);
      chk("t1_drop_s_addr", bus.s_addr, 0);
      tick();
      chk("t1_idle_ack0", bus.m0_ack, 0);
      chk("t1_idle_ack1", bus.m1_ack, 0);

      // 2: both request from reset -> alternate M0, M1, M0, M1
      idle_inputs();
      do_reset();
      bus.m0_req = 1'b1; bus.m0_addr = 32'h100;
      bus.m1_req = 1'b1; bus.m1_addr = 32'h200;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp0 = ((i % 2) == 0);
         chk("t2_m0_ack", bus.m0_ack, exp0);
         chk("t2_m1_ack", bus.m1_ack, !exp0);
         chk("t2_s_addr", bus.s_addr, exp0 ? 32'h100 : 32'h200);
      end
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      tick();

      // 3: locked M1 burst is cut after MAX_HOLD=4 beats once M0 waits
      bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_addr = 32'h300;
      tick();
      chk("t3_m1_ack_b1", bus.m1_ack, 1);
      bus.m0_req = 1'b1;
      #1;
      chk("t3_m0_wait", bus.m0_ack, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_m1_ack_burst", bus.m1_ack, 1);
         chk("t3_m0_ack_burst", bus.m0_ack, 0);
      end
      tick();
      chk("t3_m0_ack_after", bus.m0_ack, 1);
      chk("t3_m1_ack_after", bus.m1_ack, 0);
      chk("t3_s_addr_after", bus.s_addr, 32'h100);

      // 4: M1 write, then M1 drops its request -> bus returns to IDLE
      bus.m0_req  = 1'b0;
      bus.m1_lock = 1'b0;
      bus.m1_we   = 1'b1;
      bus.m1_wd   = 32'hCAFEF00D;
      #1;
      chk("t4_m0_drop", bus.m0_ack, 0);
      tick();
      chk("t4_m1_ack",  bus.m1_ack, 1);
      chk("t4_s_we",    bus.s_we,   1);
      chk("t4_s_wd",    bus.s_wd,   32'hCAFEF00D);
      chk("t4_s_addr",  bus.s_addr, 32'h300);
      bus.m1_req = 1'b0;
      #1;
      chk("t4_drop_ack",  bus.m1_ack, 0);
      chk("t4_drop_s_we", bus.s_we,   0);
      tick();
      chk("t4_idle_ack0",   bus.m0_ack, 0);
      chk("t4_idle_ack1",   bus.m1_ack, 0);
      chk("t4_idle_s_addr", bus.s_addr, 0);
      chk("t4_idle_s_we",   bus.s_we,   0);
      bus.m1_req = 1'b1;
      #1;
      chk("t4_idle_latency", bus.m1_ack, 0);
      tick();
      chk("t4_regrant_ack", bus.m1_ack, 1);
      chk("t4_regrant_we",  bus.s_we,   1);

      // 5: async reset mid-write drops ack/bus without a clock edge
      rst = 1'b1;
      #1;
      chk("t5_rst_m1_ack", bus.m1_ack, 0);
      chk("t5_rst_s_we",   bus.s_we,   0);
      chk("t5_rst_s_addr", bus.s_addr, 0);
      chk("t5_rst_s_wd",   bus.s_wd,   0);
      #1;
      rst = 1'b0;
      bus.m1_we  = 1'b0;
      bus.m0_req = 1'b1;
      #1;
      chk("t5_idle_ack0", bus.m0_ack, 0);
      chk("t5_idle_ack1", bus.m1_ack, 0);
      tick();
      chk("t5_first_m0", bus.m0_ack, 1);
      chk("t5_first_m1", bus.m1_ack, 0);
      chk("t5_first_addr", bus.s_addr, 32'h100);
      tick();
      chk("t5_second_m1", bus.m1_ack, 1);
      chk("t5_second_m0", bus.m0_ack, 0);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      tick();

`ifdef ARB_STATS_EN
      // 6: saturating beat counters with clear
      idle_inputs();
      do_reset();
      chk("t6_rst_m0_gcnt", m0_gcnt, 0);
      chk("t6_rst_m1_gcnt", m1_gcnt, 0);
      bus.m0_req = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      chk("t6_m0_gcnt_10", m0_gcnt, 4'd10);
      chk("t6_m1_gcnt_0",  m1_gcnt, 4'd0);
      for (int i = 0; i < 20; i++) tick();
      chk("t6_m0_gcnt_sat", m0_gcnt, 4'd15);
      stat_clr = 1'b1;
      tick();
      chk("t6_clr", m0_gcnt, 4'd0);
      stat_clr   = 1'b0;
      bus.m0_req = 1'b0;
      tick();
      chk("t6_after_clr", m0_gcnt, 4'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
